// File: rtl/us_shift_add_mult.sv
// Unsigned shift-add multiplier with a final two's-complement sign stage.
// Takes DATA_WIDTH iterations in RUN plus one SIGN cycle, then pulses done
// with the signed product. busy is a decode of the registered state.
module us_shift_add_mult #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     A_mag,
    input  logic [DATA_WIDTH-1:0]     B_mag,
    input  logic                      neg_result,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  done_q, done_d;
    logic [PW-1:0]         product_q, product_d;

    logic [DATA_WIDTH:0]   sum;
    logic [PW-1:0]         full;

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: latch operands, iterate shift-add, then apply sign.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        product_d = product_q;
        // The carry of the add becomes the MSB of the shifted accumulator,
        // and the LSB of the sum shifts into the vacated top of B.
        sum       = {1'b0, acc_q} + {1'b0, (b_q[0] ? a_q : '0)};
        full      = {acc_q, b_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A_mag;
                    b_d     = B_mag;
                    neg_d   = neg_result;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum[DATA_WIDTH:1];
                b_d   = {sum[0], b_q[DATA_WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                product_d = neg_q ? ((~full) + PW'(1)) : full;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_us_shift_add_mult.sv
// Self-checking bench for us_shift_add_mult: directed corner cases with
// literal expectations, then randomized traffic against an arithmetic model.
module tb_us_shift_add_mult;

    localparam int W  = 16;
    localparam int PW = 2 * W;

    logic          Clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  A_mag;
    logic [W-1:0]  B_mag;
    logic          neg_result;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    // Literal tag attached by the stimulus to a directed operation.
    logic          lit_valid;
    logic [PW-1:0] lit_val;

    int n_tests = 0;
    int n_fail  = 0;

    us_shift_add_mult #(.DATA_WIDTH(W)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .start      (start),
        .A_mag      (A_mag),
        .B_mag      (B_mag),
        .neg_result (neg_result),
        .busy       (busy),
        .done       (done),
        .product    (product)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start produces the signed product
    // DATA_WIDTH+1 edges later; busy covers the whole interval.
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [PW-1:0] m_prod = '0;
    logic [PW-1:0] m_res  = '0;
    int            m_left = 0;
    logic          op_lit_v = 1'b0;
    logic [PW-1:0] op_lit   = '0;
    logic          lit_now  = 1'b0;

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (reset) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_prod = '0;
            end else begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_prod = m_res;
                        if (op_lit_v) begin
                            chk("model_vs_literal", m_res, op_lit);
                            lit_now = 1'b1;
                        end
                    end
                end else if (start) begin
                    m_busy   = 1'b1;
                    m_left   = W + 1;
                    m_res    = PW'(A_mag) * PW'(B_mag);
                    if (neg_result) m_res = -m_res;
                    op_lit_v = lit_valid;
                    op_lit   = lit_val;
                end
            end
            @(negedge Clk);
            if (reset) begin
                m_busy  = 1'b0;
                m_done  = 1'b0;
                m_prod  = '0;
                lit_now = 1'b0;
            end
            chk("busy", PW'(busy), PW'(m_busy));
            chk("done", PW'(done), PW'(m_done));
            chk("product", product, m_prod);
            if (lit_now) chk("product_vs_literal", product, op_lit);
            lit_now = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // Presents one start for a single edge; called just after an edge.
    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic n,
                      input logic [PW-1:0] lit);
        A_mag      = a;
        B_mag      = b;
        neg_result = n;
        lit_val    = lit;
        lit_valid  = 1'b1;
        start      = 1'b1;
        @(posedge Clk);
        #2;
        start      = 1'b0;
        lit_valid  = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = W'(1);
            2:       v = '1;
            3:       v = W'(1) << (W - 1);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        A_mag      = '0;
        B_mag      = '0;
        neg_result = 1'b0;
        lit_valid  = 1'b0;
        lit_val    = '0;
        cycles(3);
        reset = 1'b0;

        go(16'd3, 16'd5, 1'b0, 32'h0000000F);
        cycles(18);
        go(16'd3, 16'd5, 1'b1, 32'hFFFFFFF1);
        cycles(18);
        go(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        cycles(18);
        go(16'h8000, 16'h8000, 1'b1, 32'hC0000000);
        cycles(18);
        go(16'h0000, 16'h1234, 1'b1, 32'h00000000);
        cycles(18);

        // Inputs disturbed mid-run, then a new start on the done cycle.
        go(16'd7, 16'd9, 1'b0, 32'h0000003F);
        cycles(4);
        start = 1'b1;
        A_mag = 16'd1;
        B_mag = 16'd1;
        neg_result = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(12);
        go(16'd11, 16'd13, 1'b1, 32'hFFFFFF71);
        cycles(18);

        // Reset in the middle of an operation, then a clean 2*2.
        go(16'd100, 16'd200, 1'b0, 32'd20000);
        cycles(7);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        go(16'd2, 16'd2, 1'b0, 32'h00000004);
        cycles(18);

        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            A_mag      = pick();
            B_mag      = pick();
            neg_result = $urandom_range(0, 1) == 1;
            reset      = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        reset = 1'b0;
        start = 1'b0;
        cycles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
